// File: rtl/sha256_msg_padder.sv
// FIPS 180-4 message padder: packs 32-bit big-endian words into 512-bit blocks, appends 0x80 + bit length.
// Optional build macro SHA256_MSG_PADDER_ERR_EN adds a sticky err_o for illegal msg_bytes_i values.
module sha256_msg_padder (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clear_i,
    input  logic [31:0]  msg_data_i,
    input  logic [2:0]   msg_bytes_i,
    input  logic         msg_last_i,
    input  logic         msg_valid_i,
    output logic         msg_ready_o,
    output logic [511:0] block_o,
    output logic         block_last_o,
    output logic         block_valid_o,
    input  logic         block_ready_i,
    output logic         busy_o
`ifdef SHA256_MSG_PADDER_ERR_EN
    ,
    output logic         err_o
`endif
);

    localparam int unsigned BlockWidth = 512;
    localparam int unsigned WordSize   = 32;
    localparam int unsigned LenWidth   = 64;

    localparam logic [0:0] StFill = 1'b0;
    localparam logic [0:0] StEmit = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [3:0]            widx_q, widx_d;
    logic [LenWidth-1:0]   len_q, len_d;
    logic [BlockWidth-1:0] block_q, block_d;
    logic                  last_q, last_d;
    logic                  valid_q, valid_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic                  tail_len_q, tail_len_d;
    logic                  tail_pad_q, tail_pad_d;

    logic [2:0]            nbytes_c;
    logic [WordSize-1:0]   mask_c;
    logic [WordSize-1:0]   word_c;
    logic [6:0]            off_c;
    logic [LenWidth-1:0]   len_add_c;
    logic [8:0]            word_base_c;
    logic [8:0]            byte_base_c;
    logic [BlockWidth-1:0] fill_c;
    logic                  accept_c;

    assign accept_c = msg_valid_i & ready_q;

    // Effective byte count: illegal codes count as a full word; 0 only for an empty message.
    always_comb begin
        nbytes_c = msg_bytes_i;
        if (msg_bytes_i > 3'd4) begin
            nbytes_c = 3'd4;
        end else if (msg_bytes_i == 3'd0 && !(msg_last_i && widx_q == 4'd0)) begin
            nbytes_c = 3'd4;
        end
    end

    always_comb begin
        case (nbytes_c)
            3'd1:    mask_c = 32'hFF00_0000;
            3'd2:    mask_c = 32'hFFFF_0000;
            3'd3:    mask_c = 32'hFFFF_FF00;
            3'd4:    mask_c = 32'hFFFF_FFFF;
            default: mask_c = 32'h0000_0000;
        endcase
    end

    assign word_c      = msg_data_i & mask_c;
    assign off_c       = 7'({widx_q, 2'b00}) + 7'(nbytes_c);
    assign len_add_c   = len_q + LenWidth'({nbytes_c, 3'b000});
    assign word_base_c = 9'd511 - {widx_q, 5'b00000};
    assign byte_base_c = 9'd511 - {off_c[5:0], 3'b000};

    // Current block with the incoming word merged, plus padding when it closes the message.
    always_comb begin
        fill_c = block_q;
        fill_c[word_base_c -: WordSize] = word_c;
        if (msg_last_i) begin
            if (off_c < 7'd64) begin
                fill_c[byte_base_c -: 8] = 8'h80;
            end
            if (off_c <= 7'd55) begin
                fill_c[LenWidth-1:0] = len_add_c;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        widx_d     = widx_q;
        len_d      = len_q;
        block_d    = block_q;
        last_d     = last_q;
        valid_d    = valid_q;
        ready_d    = ready_q;
        busy_d     = busy_q;
        tail_len_d = tail_len_q;
        tail_pad_d = tail_pad_q;
        if (clear_i) begin
            state_d    = StFill;
            widx_d     = '0;
            len_d      = '0;
            block_d    = '0;
            last_d     = 1'b0;
            valid_d    = 1'b0;
            ready_d    = 1'b1;
            busy_d     = 1'b0;
            tail_len_d = 1'b0;
            tail_pad_d = 1'b0;
        end else begin
            case (state_q)
                StFill: begin
                    if (accept_c) begin
                        block_d = fill_c;
                        len_d   = len_add_c;
                        widx_d  = widx_q + 4'd1;
                        busy_d  = 1'b1;
                        if (msg_last_i) begin
                            state_d    = StEmit;
                            valid_d    = 1'b1;
                            ready_d    = 1'b0;
                            last_d     = (off_c <= 7'd55);
                            tail_len_d = (off_c > 7'd55) && (off_c < 7'd64);
                            tail_pad_d = (off_c == 7'd64);
                        end else if (widx_q == 4'd15) begin
                            state_d = StEmit;
                            valid_d = 1'b1;
                            ready_d = 1'b0;
                            last_d  = 1'b0;
                        end
                    end
                end
                default: begin
                    if (valid_q && block_ready_i) begin
                        if (tail_len_q || tail_pad_q) begin
                            // Extra block: optional leading 0x80, then only the bit length.
                            block_d                       = '0;
                            block_d[511:480]              = tail_pad_q ? 32'h8000_0000 : 32'h0;
                            block_d[LenWidth-1:0]         = len_q;
                            last_d                        = 1'b1;
                            tail_len_d                    = 1'b0;
                            tail_pad_d                    = 1'b0;
                        end else begin
                            state_d = StFill;
                            widx_d  = '0;
                            block_d = '0;
                            valid_d = 1'b0;
                            ready_d = 1'b1;
                            last_d  = 1'b0;
                            if (last_q) begin
                                len_d  = '0;
                                busy_d = 1'b0;
                            end
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StFill;
            widx_q     <= '0;
            len_q      <= '0;
            block_q    <= '0;
            last_q     <= 1'b0;
            valid_q    <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            tail_len_q <= 1'b0;
            tail_pad_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            widx_q     <= widx_d;
            len_q      <= len_d;
            block_q    <= block_d;
            last_q     <= last_d;
            valid_q    <= valid_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            tail_len_q <= tail_len_d;
            tail_pad_q <= tail_pad_d;
        end
    end

`ifdef SHA256_MSG_PADDER_ERR_EN
    logic bad_c;
    logic err_q;

    assign bad_c = (msg_bytes_i > 3'd4) ||
                   (msg_bytes_i == 3'd0 && !(msg_last_i && widx_q == 4'd0));

    // Sticky illegal-length flag, cleared only by clear_i or reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (clear_i) begin
            err_q <= 1'b0;
        end else if (state_q == StFill && accept_c && bad_c) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`endif

    assign msg_ready_o   = ready_q;
    assign block_o       = block_q;
    assign block_last_o  = last_q;
    assign block_valid_o = valid_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder: padding vectors, backpressure hold and clear abort.
module tb_sha256_msg_padder;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         clear_i;
    logic [31:0]  msg_data_i;
    logic [2:0]   msg_bytes_i;
    logic         msg_last_i;
    logic         msg_valid_i;
    logic         msg_ready_o;
    logic [511:0] block_o;
    logic         block_last_o;
    logic         block_valid_o;
    logic         block_ready_i;
    logic         busy_o;
`ifdef SHA256_MSG_PADDER_ERR_EN
    logic         err_o;
`endif

    always #5 clk_i = ~clk_i;

    sha256_msg_padder dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .clear_i       (clear_i),
        .msg_data_i    (msg_data_i),
        .msg_bytes_i   (msg_bytes_i),
        .msg_last_i    (msg_last_i),
        .msg_valid_i   (msg_valid_i),
        .msg_ready_o   (msg_ready_o),
        .block_o       (block_o),
        .block_last_o  (block_last_o),
        .block_valid_o (block_valid_o),
        .block_ready_i (block_ready_i),
        .busy_o        (busy_o)
`ifdef SHA256_MSG_PADDER_ERR_EN
        ,
        .err_o         (err_o)
`endif
    );

    typedef struct {
        int          len;
        int          nblk;
        int          pad_blk;
        int          pad_word;
        logic [31:0] pad_val;
        logic [31:0] len_lo;
        logic        b2b;
    } vec_t;

    typedef struct {
        logic [511:0] blk;
        logic         last;
        int           cyc;
    } cap_t;

    vec_t vecs[8];
    cap_t capq[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Record every block handshake that the next rising edge will complete.
    always @(negedge clk_i) begin
        if (block_valid_o && block_ready_i) begin
            capq.push_back('{blk: block_o, last: block_last_o, cyc: cyc});
        end
    end

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] wd(input logic [511:0] b, input int w);
        return b[511 - 32*w -: 32];
    endfunction

    task automatic send_word(input logic [31:0] data, input logic [2:0] nb, input logic last);
        int   g;
        logic acc;
        g   = 0;
        acc = 1'b0;
        msg_data_i  = data;
        msg_bytes_i = nb;
        msg_last_i  = last;
        msg_valid_i = 1'b1;
        while (!acc && g < 200) begin
            @(negedge clk_i);
            acc = msg_ready_o;
            @(posedge clk_i);
            #1;
            g++;
        end
        msg_valid_i = 1'b0;
        msg_last_i  = 1'b0;
        if (!acc) check("accept_timeout", 512'(acc), 512'(1));
    endtask

    // Byte i of the message carries value i+1; bytes past the valid count are junk 0xEE.
    task automatic send_msg(input int len);
        logic [31:0] data;
        int          nb;
        if (len == 0) begin
            send_word(32'hEEEE_EEEE, 3'd0, 1'b1);
        end else begin
            for (int k = 0; 4*k < len; k++) begin
                nb = (len - 4*k > 4) ? 4 : len - 4*k;
                for (int j = 0; j < 4; j++) begin
                    data[31 - 8*j -: 8] = (j < nb) ? 8'(4*k + j + 1) : 8'hEE;
                end
                send_word(data, 3'(nb), (4*k + 4 >= len));
            end
        end
    endtask

    task automatic wait_blocks(input int n);
        int g;
        g = 0;
        while (capq.size() < n && g < 300) begin
            @(posedge clk_i);
            g++;
        end
        repeat (5) @(posedge clk_i);
        #1;
    endtask

    logic [511:0] exp_abc;
    logic [511:0] junk_hold;
    logic [7:0]   lastv;
    logic [7:0]   expv;

    initial begin
        vecs[0] = '{len: 0,   nblk: 1, pad_blk: 0, pad_word: 0,  pad_val: 32'h8000_0000, len_lo: 32'h0000_0000, b2b: 1'b0};
        vecs[1] = '{len: 3,   nblk: 1, pad_blk: 0, pad_word: 0,  pad_val: 32'h0102_0380, len_lo: 32'h0000_0018, b2b: 1'b0};
        vecs[2] = '{len: 5,   nblk: 1, pad_blk: 0, pad_word: 1,  pad_val: 32'h0580_0000, len_lo: 32'h0000_0028, b2b: 1'b0};
        vecs[3] = '{len: 55,  nblk: 1, pad_blk: 0, pad_word: 13, pad_val: 32'h3536_3780, len_lo: 32'h0000_01B8, b2b: 1'b0};
        vecs[4] = '{len: 56,  nblk: 2, pad_blk: 0, pad_word: 14, pad_val: 32'h8000_0000, len_lo: 32'h0000_01C0, b2b: 1'b1};
        vecs[5] = '{len: 62,  nblk: 2, pad_blk: 0, pad_word: 15, pad_val: 32'h3D3E_8000, len_lo: 32'h0000_01F0, b2b: 1'b1};
        vecs[6] = '{len: 64,  nblk: 2, pad_blk: 1, pad_word: 0,  pad_val: 32'h8000_0000, len_lo: 32'h0000_0200, b2b: 1'b1};
        vecs[7] = '{len: 100, nblk: 2, pad_blk: 1, pad_word: 9,  pad_val: 32'h8000_0000, len_lo: 32'h0000_0320, b2b: 1'b0};

        exp_abc           = '0;
        exp_abc[511:480]  = 32'h6162_6380;
        exp_abc[31:0]     = 32'h0000_0018;

        rst_ni        = 1'b0;
        clear_i       = 1'b0;
        msg_data_i    = '0;
        msg_bytes_i   = '0;
        msg_last_i    = 1'b0;
        msg_valid_i   = 1'b0;
        block_ready_i = 1'b0;
        #12;
        check("rst_ready", 512'(msg_ready_o), 512'(1));
        check("rst_valid", 512'(block_valid_o), 512'(0));
        check("rst_last", 512'(block_last_o), 512'(0));
        check("rst_busy", 512'(busy_o), 512'(0));
        check("rst_block", block_o, '0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // "abc" single word: block one cycle later, then held under 10 cycles of backpressure.
        msg_data_i  = 32'h6162_6300;
        msg_bytes_i = 3'd3;
        msg_last_i  = 1'b1;
        msg_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        msg_last_i  = 1'b0;
        msg_valid_i = 1'b0;
        check("abc_valid", 512'(block_valid_o), 512'(1));
        check("abc_block", block_o, exp_abc);
        check("abc_last", 512'(block_last_o), 512'(1));
        check("abc_ready", 512'(msg_ready_o), 512'(0));
        check("abc_busy", 512'(busy_o), 512'(1));
        msg_data_i  = 32'hDEAD_BEEF;
        msg_bytes_i = 3'd4;
        msg_valid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_i);
            #1;
            check("bp_block", block_o, exp_abc);
            check("bp_valid", 512'(block_valid_o), 512'(1));
            check("bp_ready", 512'(msg_ready_o), 512'(0));
        end
        block_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        msg_valid_i = 1'b0;
        check("hs_valid", 512'(block_valid_o), 512'(0));
        check("hs_busy", 512'(busy_o), 512'(0));
        check("hs_ready", 512'(msg_ready_o), 512'(1));
        check("hs_block", block_o, '0);

        // Abort a message after 7 words, then "abc" must produce the exact same block.
        for (int k = 0; k < 7; k++) send_word(32'h1111_1111 * (k + 1), 3'd4, 1'b0);
        check("clr_busy_before", 512'(busy_o), 512'(1));
        clear_i = 1'b1;
        @(posedge clk_i);
        #1;
        clear_i = 1'b0;
        check("clr_busy", 512'(busy_o), 512'(0));
        check("clr_ready", 512'(msg_ready_o), 512'(1));
        check("clr_valid", 512'(block_valid_o), 512'(0));
        capq.delete();
        send_word(32'h6162_6300, 3'd3, 1'b1);
        wait_blocks(1);
        check("clr_nblk", 512'(capq.size()), 512'(1));
        if (capq.size() >= 1) check("clr_abc_block", capq[0].blk, exp_abc);

        // Table vectors with the block side always ready.
        for (int v = 0; v < 8; v++) begin
            capq.delete();
            send_msg(vecs[v].len);
            wait_blocks(vecs[v].nblk);
            check($sformatf("v%0d_nblk", vecs[v].len), 512'(capq.size()), 512'(vecs[v].nblk));
            if (capq.size() == vecs[v].nblk) begin
                check($sformatf("v%0d_pad", vecs[v].len),
                      512'(wd(capq[vecs[v].pad_blk].blk, vecs[v].pad_word)), 512'(vecs[v].pad_val));
                check($sformatf("v%0d_w15", vecs[v].len),
                      512'(wd(capq[vecs[v].nblk - 1].blk, 15)), 512'(vecs[v].len_lo));
                check($sformatf("v%0d_w14", vecs[v].len),
                      512'(wd(capq[vecs[v].nblk - 1].blk, 14)), 512'(0));
                lastv = '0;
                expv  = '0;
                for (int b = 0; b < vecs[v].nblk; b++) lastv[b] = capq[b].last;
                expv[vecs[v].nblk - 1] = 1'b1;
                check($sformatf("v%0d_lastflags", vecs[v].len), 512'(lastv), 512'(expv));
                if (vecs[v].len >= 4) begin
                    check($sformatf("v%0d_w0", vecs[v].len), 512'(wd(capq[0].blk, 0)), 512'(32'h0102_0304));
                end
                if (vecs[v].b2b) begin
                    check($sformatf("v%0d_b2b", vecs[v].len), 512'(capq[1].cyc - capq[0].cyc), 512'(1));
                end
            end
            check($sformatf("v%0d_idle_busy", vecs[v].len), 512'(busy_o), 512'(0));
            check($sformatf("v%0d_idle_ready", vecs[v].len), 512'(msg_ready_o), 512'(1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
